// File: rtl/lfst_multi.sv
// -----------------------------------------------------------------------------
// lfst_multi -- last-fetched-store table for store-set memory dependence
// prediction.
//
// The table maps a store-set ID (SSID) to the tag of the most recent in-flight
// store of that set. It sits in rename. Each cycle it serves NRD lookups,
// NUP store updates and NINV retire invalidates.
//
// Lookups are combinational from registered state. Writes made in a cycle
// become visible in the next cycle.
//
// Next-state precedence for each entry, highest first:
//   1. flush or periodic clear   -> vld cleared, tag kept
//   2. update (youngest port)    -> new tag, vld set
//   3. invalidate tag match (CAM) -> vld cleared
//   4. hold
//
// Ports
//   clock          in   1               rising-edge clock
//   reset          in   1               asynchronous, active-high reset
//   flush_in       in   1               invalidate all entries
//   rd_ssid_in     in   NRD*SSID_W      lookup SSIDs, port k at [k*SSID_W +: SSID_W]
//   rd_vld_in      in   NRD             lookup request valid
//   upd_vld_in     in   NUP             update valid (higher index = younger)
//   upd_ssid_in    in   NUP*SSID_W      SSID to write
//   upd_tag_in     in   NUP*TAG_W       store tag to write
//   inv_vld_in     in   NINV            retiring-store invalidate valid
//   inv_tag_in     in   NINV*TAG_W      tag of retiring store
//   lfs_out        out  NRD*TAG_W       stored tag for each lookup SSID
//   lfs_vld_out    out  NRD             entry valid AND rd_vld_in[k]
//   clr_pulse_out  out  1               registered pulse, one per periodic clear
// -----------------------------------------------------------------------------
module lfst_multi #(
  parameter int SSID_W  = 7,
  parameter int TAG_W   = 7,
  parameter int NRD     = 4,
  parameter int NUP     = 4,
  parameter int NINV    = 2,
  parameter int CLR_PER = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_in,
  input  logic [NRD*SSID_W-1:0] rd_ssid_in,
  input  logic [NRD-1:0]        rd_vld_in,
  input  logic [NUP-1:0]        upd_vld_in,
  input  logic [NUP*SSID_W-1:0] upd_ssid_in,
  input  logic [NUP*TAG_W-1:0]  upd_tag_in,
  input  logic [NINV-1:0]       inv_vld_in,
  input  logic [NINV*TAG_W-1:0] inv_tag_in,
  output logic [NRD*TAG_W-1:0]  lfs_out,
  output logic [NRD-1:0]        lfs_vld_out,
  output logic                  clr_pulse_out
);

  localparam int DEPTH = 1 << SSID_W;
  // Terminal count of the clear timer. The timer is unused when CLR_PER is 0.
  localparam logic [19:0] CLR_LAST = (CLR_PER > 0) ? 20'(CLR_PER - 1) : 20'd0;

  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [19:0]      cnt_q;
  logic [19:0]      cnt_d;
  logic             clr_pulse_q;
  logic             clr_pulse_d;
  logic             clr_fire;

  // Periodic clear timer. It free-runs from reset and is deliberately not
  // restarted by flush_in, so the clear cadence never drifts.
  always_comb begin : clear_timer
    clr_fire = 1'b0;
    cnt_d    = '0;
    if (CLR_PER > 0) begin
      if (cnt_q == CLR_LAST) begin
        clr_fire = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
    clr_pulse_d = clr_fire;
  end

  // Table next state. The passes are ordered lowest to highest precedence, so
  // each later pass simply overrides the earlier ones.
  always_comb begin : table_next
    // Pass 1: retire invalidates. The CAM compares against pre-edge tags, and
    // every matching entry is cleared.
    for (int e = 0; e < DEPTH; e++) begin
      tag_d[e] = tag_q[e];
      vld_d[e] = vld_q[e];
      for (int m = 0; m < NINV; m++) begin
        if (inv_vld_in[m] && (inv_tag_in[m*TAG_W +: TAG_W] == tag_q[e])) begin
          vld_d[e] = 1'b0;
        end
      end
    end
    // Pass 2: updates. Ports are walked oldest to youngest, so the youngest
    // writer of an SSID lands last and wins.
    for (int j = 0; j < NUP; j++) begin
      if (upd_vld_in[j]) begin
        tag_d[upd_ssid_in[j*SSID_W +: SSID_W]] = upd_tag_in[j*TAG_W +: TAG_W];
        vld_d[upd_ssid_in[j*SSID_W +: SSID_W]] = 1'b1;
      end
    end
    // Pass 3: flush or periodic clear. This drops every valid bit and leaves
    // the tags exactly as they were before the edge.
    if (flush_in || clr_fire) begin
      for (int e = 0; e < DEPTH; e++) begin
        tag_d[e] = tag_q[e];
        vld_d[e] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        tag_q[e] <= '0;
      end
      vld_q       <= '0;
      cnt_q       <= '0;
      clr_pulse_q <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        tag_q[e] <= tag_d[e];
      end
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      clr_pulse_q <= clr_pulse_d;
    end
  end

  // Zero-latency lookups. The tag is driven even when the request is not
  // valid; only the valid output is qualified by rd_vld_in.
  always_comb begin : lookup
    lfs_out     = '0;
    lfs_vld_out = '0;
    for (int k = 0; k < NRD; k++) begin
      lfs_out[k*TAG_W +: TAG_W] = tag_q[rd_ssid_in[k*SSID_W +: SSID_W]];
      lfs_vld_out[k]            = vld_q[rd_ssid_in[k*SSID_W +: SSID_W]] & rd_vld_in[k];
    end
  end

  assign clr_pulse_out = clr_pulse_q;

endmodule
